// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider and 640x480 VGA raster timing (X/Y, blanking, syncs, frame strobe)
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       CE,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       VIDEO_ON,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       FRAME_TICK
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div;
    logic [9:0]    x_nxt, y_nxt;
    logic          line_end;

    // CE decode and next raster position; syncs/blanking are loaded from these so they stay aligned with X/Y
    always_comb begin
        CE       = div == DW'(CLK_DIV - 1);
        line_end = CE && X == 10'(H_TOTAL - 1);
        x_nxt    = CE ? (line_end ? '0 : X + 10'd1) : X;
        y_nxt    = line_end ? (Y == 10'(V_TOTAL - 1) ? '0 : Y + 10'd1) : Y;
    end

    // divider, raster counters and registered timing outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div        <= '0;
            X          <= '0;
            Y          <= '0;
            VIDEO_ON   <= 1'b1;
            HSYNC      <= 1'b1;
            VSYNC      <= 1'b1;
            FRAME_TICK <= 1'b0;
        end else begin
            div        <= CE ? '0 : div + DW'(1);
            X          <= x_nxt;
            Y          <= y_nxt;
            VIDEO_ON   <= x_nxt < 10'(H_DISPLAY) && y_nxt < 10'(V_DISPLAY);
            HSYNC      <= !(x_nxt >= 10'(H_DISPLAY + H_FRONT) && x_nxt < 10'(H_DISPLAY + H_FRONT + H_SYNC));
            VSYNC      <= !(y_nxt >= 10'(V_DISPLAY + V_FRONT) && y_nxt < 10'(V_DISPLAY + V_FRONT + V_SYNC));
            FRAME_TICK <= line_end && Y == 10'(V_DISPLAY);
        end
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480@60 Hz VGA output path. Sits directly upstream of the pixel generator. It divides the system clock down to the pixel rate, produces the pixel clock-enable, the current pixel coordinates X/Y, the VIDEO_ON blanking flag and the active-low HSYNC/VSYNC pulses. The pixel generator consumes CE, X, Y and VIDEO_ON. HSYNC/VSYNC go straight to the connector alongside its RGB output.

## Interface

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz to 25 MHz); legal range 1..16
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- CLK  in  1  system clock; one clock domain
- RESET_N  in  1  asynchronous, active-low reset
- CE  out  1  pixel enable; high for one CLK cycle every CLK_DIV cycles
- X  out  10  current column, 0..H_TOTAL-1
- Y  out  10  current line, 0..V_TOTAL-1
- VIDEO_ON  out  1  high when X < H_DISPLAY and Y < V_DISPLAY
- HSYNC  out  1  active-low horizontal sync
- VSYNC  out  1  active-low vertical sync
- FRAME_TICK  out  1  one-CLK pulse once per frame, at the first CLK cycle of pixel (0, V_DISPLAY+1)

## Operation

- Derived values:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800).
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK (525).
- Divider:
  - div counter runs 0..CLK_DIV-1 and wraps.
  - CE = (div == CLK_DIV-1), decoded combinationally from the registered counter.
  - With CLK_DIV = 1, CE is constantly 1 after reset.
- Horizontal counter:
  - On a CLK edge with CE = 1, X increments.
  - At X == H_TOTAL-1, X wraps to 0 and the line-end event fires.
- Vertical counter:
  - Advances only on a line-end event.
  - At Y == V_TOTAL-1, Y wraps to 0.
  - X and Y wrap on the same edge at (799, 524) to (0, 0).
- Registered outputs: HSYNC, VSYNC and VIDEO_ON are registers loaded from the next-state X/Y values, so they are always aligned with the X/Y they describe.
  - HSYNC = 0 iff H_DISPLAY+H_FRONT ≤ X < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - VSYNC = 0 iff V_DISPLAY+V_FRONT ≤ Y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
  - VIDEO_ON = (X < 640) && (Y < 480).
- FRAME_TICK:
  - Registered.
  - Set on the edge where X/Y transition to (0, V_DISPLAY+1).
  - Cleared on the next CLK edge.
  - It is the pixel generator's 60 Hz update strobe.
- Counters never hold an out-of-range value: X ≤ 799 and Y ≤ 524 at all times.

## Timing

- Reset (RESET_N = 0, asynchronous, takes effect immediately, including mid-line or mid-frame):
  - Counters: div = 0, X = 0, Y = 0.
  - Outputs: CE = 0 (1 if CLK_DIV = 1), VIDEO_ON = 1, HSYNC = 1, VSYNC = 1, FRAME_TICK = 0.
- Release: the counters restart from the state above. The first CE is in CLK cycle CLK_DIV-1 after the first edge following release.
- Latency: X/Y, VIDEO_ON, HSYNC and VSYNC all change on the same CLK edge as the CE-qualified counter update. There is zero relative skew between them.
- Between CE pulses, every output is held constant for CLK_DIV CLK cycles.
- Line period is H_TOTAL×CLK_DIV CLK cycles (3200). Frame period is V_TOTAL line periods (1,680,000 CLK cycles).
- FRAME_TICK period equals the frame period. The first pulse after reset comes at Y = 481, X = 0.

## Test plan

- Reset behaviour: assert RESET_N = 0 mid-line at X = 300, Y = 200, asynchronously between edges.
  - Required: X = 0, Y = 0, HSYNC = 1, VSYNC = 1, VIDEO_ON = 1, FRAME_TICK = 0 immediately.
  - Required after release: CE first high in cycle 3, X = 1 after cycle 4.
- CE cadence with CLK_DIV = 4: over 40 CLK cycles, CE is high exactly 10 times, evenly spaced 4 apart. With CLK_DIV = 1, CE is high every cycle and X advances every edge.
- Horizontal timing: over one line, HSYNC is low for exactly 96 pixels (X = 656..751). VIDEO_ON drops on the edge where X goes 639 to 640. The line lasts 3200 CLK.
- Vertical wrap and VSYNC:
  - X = 799, Y = 524 goes to (0, 0) on one CE edge.
  - VSYNC is low only for Y = 490..491, i.e. 1600 pixels.
  - VIDEO_ON is 0 for all of Y = 480..524.
- FRAME_TICK:
  - Exactly one 1-CLK pulse per 1,680,000 cycles, coincident with the first cycle of X = 0, Y = 481.
  - No pulse during the remaining CLK_DIV-1 cycles of that pixel.
- Pixel-generator hookup (CLK_DIV = 4): drive the pixel generator from this block.
  - The ball position advances by ±2 exactly once per frame.
  - RGB = 0 whenever VIDEO_ON = 0.
